// File: rtl/spi_pkg.sv
// Purpose: shared constants and types for the SPI mode-0 responder (and its master).
// Contents: FSM state enum, default frame width / idle word, SPI mode constants.
// No ports; imported by spi_slave.
package spi_pkg;

  // Clock polarity / phase shared with the master: SCK idles low, sample on rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int SPI_DATA_WIDTH = 8;

  // Word driven on MISO when local logic has nothing queued.
  localparam logic [SPI_DATA_WIDTH-1:0] SPI_IDLE_WORD = '1;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Purpose: N-stage synchroniser for an asynchronous input, with registered level and
//          single-cycle registered rise/fall pulses.
// Ports: clk_i, rst_i (async, active-high), d_i (async in), q_o (sync level), rise_o, fall_o.
// Latency: d_i change appears on q_o, rise_o and fall_o STAGES+1 clk_i cycles later.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              q_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      q_q    <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      q_q    <= sync_q[STAGES-1];
      // Pulses are registered so they line up with the q_q update.
      rise_q <= sync_q[STAGES-1] & ~q_q;
      fall_q <= ~sync_q[STAGES-1] & q_q;
    end
  end

  assign q_o    = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// Purpose: SPI mode-0 target; oversamples SCK/SS/MOSI in clk_i, shifts words MSB first.
// Ports: spi_ss_i/spi_sck_i/spi_mosi_i async SPI inputs, spi_miso_o/spi_miso_oe_o out;
//        tx_data_i/tx_valid_i/tx_ready_o load a one-word holding register;
//        rx_data_o/rx_valid_o deliver received words; tx_underrun_o, busy_o status.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_ss_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic ss_sync, ss_rise, ss_fall;
  logic sck_sync, sck_rise, sck_fall;
  logic mosi_s;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (spi_ss_i),
    .q_o   (ss_sync),
    .rise_o(ss_rise),
    .fall_o(ss_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sck_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (spi_sck_i),
    .q_o   (sck_sync),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  // MOSI gets the same depth as the SCK level path (sync chain + edge register),
  // so the bit seen alongside sck_rise is the one present at the SCK edge.
  logic [SYNC_STAGES:0] mosi_sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-1:0], spi_mosi_i};
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES];

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  word_done_q, word_done_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  reload;
  logic [DATA_WIDTH-1:0] rx_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SPI_IDLE;
      tx_sr_q     <= '1;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      word_done_q <= word_done_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    word_done_d = word_done_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    reload      = 1'b0;
    rx_next     = {rx_sr_q[DATA_WIDTH-2:0], mosi_s};

    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      SPI_IDLE: begin
        if (ss_fall) begin
          state_d     = SPI_ACTIVE;
          reload      = 1'b1;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
        end
      end
      SPI_ACTIVE: begin
        if (ss_rise) begin
          // Abandon any partial word; the holding register is left untouched.
          state_d     = SPI_IDLE;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
        end else if (!ss_sync) begin
          if (sck_rise) begin
            rx_sr_d = rx_next;
            if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              rx_data_d   = rx_next;
              rx_valid_d  = 1'b1;
              bit_cnt_d   = '0;
              word_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (sck_fall) begin
            if (word_done_q) begin
              reload      = 1'b1;
              word_done_d = 1'b0;
            end else begin
              tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b1};
            end
          end
        end
      end
      default: state_d = SPI_IDLE;
    endcase

    // Reload looks only at the registered full flag, so a same-cycle write is
    // not bypassed: it stays queued for the next word and this word underruns.
    if (reload) begin
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d    = IDLE_WORD;
        underrun_d = 1'b1;
      end
    end
  end

  assign spi_miso_o    = tx_sr_q[DATA_WIDTH-1];
  assign busy_o        = ~ss_sync;
  assign spi_miso_oe_o = ~ss_sync;
  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       underrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int         rx_cnt = 0;
  int         urun_cnt = 0;
  logic [7:0] rx_log [64];

  spi_slave dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .spi_ss_i     (ss),
    .spi_sck_i    (sck),
    .spi_mosi_i   (mosi),
    .spi_miso_o   (miso),
    .spi_miso_oe_o(miso_oe),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .tx_underrun_o(underrun),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: logs every received word and counts underrun pulses.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[5:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (underrun) urun_cnt <= urun_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    int t;
    t = 0;
    while (!tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      $display("FAIL push_timeout: tx_ready=%b required 1", tx_ready);
      errors++;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Master side: sck = clk/8, MOSI set at SCK fall, MISO sampled just before SCK rise.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      wait_clks(4);
      mi[i] = miso;
      sck = 1'b1;
      wait_clks(4);
      sck = 1'b0;
    end
  endtask

  task automatic select_slave();
    ss = 1'b0;
    wait_clks(8);
  endtask

  task automatic deselect_slave();
    wait_clks(8);
    ss = 1'b1;
    wait_clks(8);
  endtask

  task automatic test_reset();
    wait_clks(3);
    checks += 7;
    if (miso !== 1'b1)      begin $display("FAIL reset_miso: got %b want 1", miso); errors++; end
    if (miso_oe !== 1'b0)   begin $display("FAIL reset_oe: got %b want 0", miso_oe); errors++; end
    if (tx_ready !== 1'b1)  begin $display("FAIL reset_tx_ready: got %b want 1", tx_ready); errors++; end
    if (rx_data !== 8'h00)  begin $display("FAIL reset_rx_data: got %h want 00", rx_data); errors++; end
    if (rx_valid !== 1'b0)  begin $display("FAIL reset_rx_valid: got %b want 0", rx_valid); errors++; end
    if (underrun !== 1'b0)  begin $display("FAIL reset_underrun: got %b want 0", underrun); errors++; end
    if (busy !== 1'b0)      begin $display("FAIL reset_busy: got %b want 0", busy); errors++; end
    rst = 1'b0;
    wait_clks(5);
  endtask

  task automatic test_basic();
    logic [7:0] mi;
    int rx_base, u_base;
    rx_base = rx_cnt;
    u_base  = urun_cnt;
    push_tx(8'hA5);
    select_slave();
    checks += 3;
    if (busy !== 1'b1)     begin $display("FAIL basic_busy: got %b want 1", busy); errors++; end
    if (miso_oe !== 1'b1)  begin $display("FAIL basic_oe: got %b want 1", miso_oe); errors++; end
    if (tx_ready !== 1'b1) begin $display("FAIL basic_ready_after_load: got %b want 1", tx_ready); errors++; end
    spi_bits(8'h3C, 8, mi);
    wait_clks(6);
    checks += 3;
    if (mi !== 8'hA5) begin $display("FAIL basic_miso: got %h want a5", mi); errors++; end
    if (rx_cnt - rx_base != 1) begin $display("FAIL basic_rx_pulses: got %0d want 1", rx_cnt - rx_base); errors++; end
    if (rx_data !== 8'h3C) begin $display("FAIL basic_rx_data: got %h want 3c", rx_data); errors++; end
    deselect_slave();
    checks += 2;
    if (urun_cnt - u_base != 1) begin $display("FAIL basic_trailing_underrun: got %0d want 1", urun_cnt - u_base); errors++; end
    if (busy !== 1'b0) begin $display("FAIL basic_busy_release: got %b want 0", busy); errors++; end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m0, m1, m2;
    int rx_base, u_base;
    rx_base = rx_cnt;
    u_base  = urun_cnt;
    push_tx(8'h01);
    select_slave();
    push_tx(8'h02);
    spi_bits(8'h10, 8, m0);
    push_tx(8'h03);
    spi_bits(8'h20, 8, m1);
    spi_bits(8'h30, 8, m2);
    deselect_slave();
    checks += 8;
    if (m0 !== 8'h01) begin $display("FAIL b2b_miso0: got %h want 01", m0); errors++; end
    if (m1 !== 8'h02) begin $display("FAIL b2b_miso1: got %h want 02", m1); errors++; end
    if (m2 !== 8'h03) begin $display("FAIL b2b_miso2: got %h want 03", m2); errors++; end
    if (rx_cnt - rx_base != 3) begin $display("FAIL b2b_rx_pulses: got %0d want 3", rx_cnt - rx_base); errors++; end
    if (rx_log[rx_base[5:0]] !== 8'h10) begin $display("FAIL b2b_rx0: got %h want 10", rx_log[rx_base[5:0]]); errors++; end
    if (rx_log[6'(rx_base + 1)] !== 8'h20) begin $display("FAIL b2b_rx1: got %h want 20", rx_log[6'(rx_base + 1)]); errors++; end
    if (rx_log[6'(rx_base + 2)] !== 8'h30) begin $display("FAIL b2b_rx2: got %h want 30", rx_log[6'(rx_base + 2)]); errors++; end
    if (urun_cnt - u_base != 1) begin $display("FAIL b2b_underrun: got %0d want 1", urun_cnt - u_base); errors++; end
  endtask

  task automatic test_underrun();
    logic [7:0] m0, m1;
    int u_base;
    u_base = urun_cnt;
    select_slave();
    spi_bits(8'h81, 8, m0);
    spi_bits(8'h7E, 8, m1);
    deselect_slave();
    checks += 4;
    if (m0 !== 8'hFF) begin $display("FAIL urun_miso0: got %h want ff", m0); errors++; end
    if (m1 !== 8'hFF) begin $display("FAIL urun_miso1: got %h want ff", m1); errors++; end
    if (urun_cnt - u_base != 3) begin $display("FAIL urun_pulses: got %0d want 3", urun_cnt - u_base); errors++; end
    if (rx_data !== 8'h7E) begin $display("FAIL urun_rx_data: got %h want 7e", rx_data); errors++; end
  endtask

  task automatic test_partial_frame();
    logic [7:0] mi;
    int rx_base;
    rx_base = rx_cnt;
    select_slave();
    spi_bits(8'hF0, 5, mi);
    deselect_slave();
    checks += 3;
    if (mi !== 8'hF8) begin $display("FAIL partial_miso: got %h want f8", mi); errors++; end
    if (rx_cnt != rx_base) begin $display("FAIL partial_rx_pulses: got %0d want 0", rx_cnt - rx_base); errors++; end
    if (rx_data !== 8'h7E) begin $display("FAIL partial_rx_hold: got %h want 7e", rx_data); errors++; end
    push_tx(8'hC3);
    select_slave();
    spi_bits(8'h5A, 8, mi);
    deselect_slave();
    checks += 3;
    if (mi !== 8'hC3) begin $display("FAIL partial_next_miso: got %h want c3", mi); errors++; end
    if (rx_cnt - rx_base != 1) begin $display("FAIL partial_next_pulses: got %0d want 1", rx_cnt - rx_base); errors++; end
    if (rx_data !== 8'h5A) begin $display("FAIL partial_next_rx: got %h want 5a", rx_data); errors++; end
  endtask

  task automatic test_reload_collision();
    logic [7:0] m0, m1;
    int u_base;
    u_base = urun_cnt;
    // The select reload happens on the 4th rising clk edge after SS falls; the
    // write is timed onto that same edge.
    ss = 1'b0;
    wait_clks(3);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_clks(4);
    spi_bits(8'h00, 8, m0);
    checks += 3;
    if (m0 !== 8'hFF) begin $display("FAIL collide_miso0: got %h want ff", m0); errors++; end
    if (urun_cnt - u_base != 1) begin $display("FAIL collide_underrun0: got %0d want 1", urun_cnt - u_base); errors++; end
    if (tx_ready !== 1'b0) begin $display("FAIL collide_held: tx_ready=%b want 0", tx_ready); errors++; end
    spi_bits(8'h00, 8, m1);
    deselect_slave();
    checks += 2;
    if (m1 !== 8'h55) begin $display("FAIL collide_miso1: got %h want 55", m1); errors++; end
    if (urun_cnt - u_base != 2) begin $display("FAIL collide_underrun1: got %0d want 2", urun_cnt - u_base); errors++; end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] mi;
    push_tx(8'hAA);
    select_slave();
    spi_bits(8'hFF, 4, mi);
    rst = 1'b1;
    ss  = 1'b1;
    #1;
    checks += 7;
    if (miso !== 1'b1)     begin $display("FAIL midrst_miso: got %b want 1", miso); errors++; end
    if (miso_oe !== 1'b0)  begin $display("FAIL midrst_oe: got %b want 0", miso_oe); errors++; end
    if (busy !== 1'b0)     begin $display("FAIL midrst_busy: got %b want 0", busy); errors++; end
    if (tx_ready !== 1'b1) begin $display("FAIL midrst_ready: got %b want 1", tx_ready); errors++; end
    if (rx_data !== 8'h00) begin $display("FAIL midrst_rx_data: got %h want 00", rx_data); errors++; end
    if (rx_valid !== 1'b0) begin $display("FAIL midrst_rx_valid: got %b want 0", rx_valid); errors++; end
    if (underrun !== 1'b0) begin $display("FAIL midrst_underrun: got %b want 0", underrun); errors++; end
    wait_clks(3);
    rst = 1'b0;
    wait_clks(5);
    push_tx(8'h96);
    select_slave();
    spi_bits(8'h69, 8, mi);
    wait_clks(6);
    checks += 2;
    if (mi !== 8'h96) begin $display("FAIL midrst_fresh_miso: got %h want 96", mi); errors++; end
    if (rx_data !== 8'h69) begin $display("FAIL midrst_fresh_rx: got %h want 69", rx_data); errors++; end
    deselect_slave();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_partial_frame();
    test_reload_collision();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
